// File: rtl/uart_pkg.sv
// Shared UART constants: data/timeout widths and the RX register map
// used by the peripheral register interface.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_RX_TIMEOUT_W = 16;

  localparam logic [7:0] UART_RX_DATA_OFS    = 8'h20;
  localparam logic [7:0] UART_RX_COUNT_OFS   = 8'h24;
  localparam logic [7:0] UART_RX_THRESH_OFS  = 8'h28;
  localparam logic [7:0] UART_RX_TIMEOUT_OFS = 8'h2C;
  localparam logic [7:0] UART_RX_FLAGS_OFS   = 8'h30;

  typedef enum logic [2:0] {
    RX_DATA,
    RX_COUNT,
    RX_THRESH,
    RX_TIMEOUT,
    RX_FLAGS
  } uart_rx_reg_e;

  // Bit layout of the RX_FLAGS register as seen by software
  typedef struct packed {
    logic intr;
    logic timeout;
    logic overrun;
    logic full;
    logic empty;
  } uart_rx_flags_t;

  function automatic logic [7:0] uart_rx_reg_offset(uart_rx_reg_e sel);
    logic [7:0] ofs;
    case (sel)
      RX_DATA:    ofs = UART_RX_DATA_OFS;
      RX_COUNT:   ofs = UART_RX_COUNT_OFS;
      RX_THRESH:  ofs = UART_RX_THRESH_OFS;
      RX_TIMEOUT: ofs = UART_RX_TIMEOUT_OFS;
      RX_FLAGS:   ofs = UART_RX_FLAGS_OFS;
      default:    ofs = 8'h00;
    endcase
    return ofs;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 register-array storage for the RX FIFO: one synchronous
// write port, one asynchronous read port, no reset on the contents.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [UART_DATA_W-1:0] rd_data
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver, with sticky overrun,
// character-idle timeout and a threshold/timeout receive interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [UART_DATA_W-1:0]       rx_byte_i,
  input  logic                         rx_valid_i,
  input  logic                         pop_i,
  input  logic                         clr_i,
  input  logic                         ovr_clr_i,
  input  logic [AW:0]                  thresh_i,
  input  logic [UART_RX_TIMEOUT_W-1:0] timeout_i,
  output logic [UART_DATA_W-1:0]       rdata_o,
  output logic [AW:0]                  count_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         overrun_o,
  output logic                         timeout_o,
  output logic                         intr_rx_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]                  wr_ptr;
  logic [AW-1:0]                  rd_ptr;
  logic [AW:0]                    count;
  logic [UART_RX_TIMEOUT_W-1:0]   idle;
  logic                           overrun;
  logic                           timeout;
  logic                           intr;
  logic [UART_DATA_W-1:0]         head;

  logic is_empty;
  logic is_full;
  logic do_push;
  logic do_pop;
  logic drop;
  logic thresh_hit;

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte
  assign do_push = rx_valid_i && !clr_i && (!is_full || pop_i);
  assign do_pop  = pop_i && !clr_i && !is_empty;
  assign drop    = rx_valid_i && !clr_i && is_full && !pop_i;

  assign thresh_hit = (thresh_i != '0) && (count >= thresh_i);

  uart_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk     (clk_i),
    .wr_en   (do_push),
    .wr_addr (wr_ptr),
    .wr_data (rx_byte_i),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Idle counter only runs while data sits unread; any FIFO activity restarts it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle    <= '0;
      timeout <= 1'b0;
      overrun <= 1'b0;
      intr    <= 1'b0;
    end else begin
      if (do_push || do_pop || clr_i || is_empty) begin
        idle <= '0;
      end else if (idle < timeout_i) begin
        idle <= idle + 1'b1;
      end

      if (do_push || do_pop || clr_i) begin
        timeout <= 1'b0;
      end else if ((timeout_i != '0) && !is_empty && (idle == timeout_i)) begin
        timeout <= 1'b1;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr_i) begin
        overrun <= 1'b0;
      end

      intr <= thresh_hit || timeout;
    end
  end

  assign rdata_o   = is_empty ? '0 : head;
  assign count_o   = count;
  assign empty_o   = is_empty;
  assign full_o    = is_full;
  assign overrun_o = overrun;
  assign timeout_o = timeout;
  assign intr_rx_o = intr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  rx_byte_i;
  logic        rx_valid_i;
  logic        pop_i;
  logic        clr_i;
  logic        ovr_clr_i;
  logic [AW:0] thresh_i;
  logic [15:0] timeout_i;
  logic [7:0]  rdata_o;
  logic [AW:0] count_o;
  logic        empty_o;
  logic        full_o;
  logic        overrun_o;
  logic        timeout_o;
  logic        intr_rx_o;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Reference model state: stored bytes plus flags and idle cycle count
  logic [7:0] mq[$];
  int         m_idle;
  bit         m_to;
  bit         m_ovr;
  bit         m_intr;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rx_byte_i  (rx_byte_i),
    .rx_valid_i (rx_valid_i),
    .pop_i      (pop_i),
    .clr_i      (clr_i),
    .ovr_clr_i  (ovr_clr_i),
    .thresh_i   (thresh_i),
    .timeout_i  (timeout_i),
    .rdata_o    (rdata_o),
    .count_o    (count_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .overrun_o  (overrun_o),
    .timeout_o  (timeout_o),
    .intr_rx_o  (intr_rx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [7:0] modelHead();
    return (mq.size() != 0) ? mq[0] : 8'h00;
  endfunction

  task automatic modelReset();
    mq.delete();
    m_idle = 0;
    m_to   = 1'b0;
    m_ovr  = 1'b0;
    m_intr = 1'b0;
  endtask

  // One clock edge of the FIFO's rules, using the inputs held across that edge
  task automatic modelStep();
    int cnt;
    bit push_ok, pop_ok, drop, active;
    if (!rst_ni) return;
    cnt     = mq.size();
    push_ok = rx_valid_i && !clr_i && (cnt < DEPTH || pop_i);
    pop_ok  = pop_i && !clr_i && (cnt > 0);
    drop    = rx_valid_i && !clr_i && (cnt == DEPTH) && !pop_i;
    active  = push_ok || pop_ok || clr_i;

    m_intr = ((thresh_i != 0) && (cnt >= int'(thresh_i))) || m_to;
    if (active) m_to = 1'b0;
    else if ((timeout_i != 0) && (cnt != 0) && (m_idle == int'(timeout_i))) m_to = 1'b1;
    if (active || cnt == 0) m_idle = 0;
    else if (m_idle < int'(timeout_i)) m_idle = m_idle + 1;
    if (drop) m_ovr = 1'b1;
    else if (ovr_clr_i) m_ovr = 1'b0;

    if (clr_i) mq.delete();
    else begin
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(rx_byte_i);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic p,
                               input logic c, input logic oc);
    rx_valid_i = v;
    rx_byte_i  = b;
    pop_i      = p;
    clr_i      = c;
    ovr_clr_i  = oc;
    @(posedge clk_i);
    modelStep();
    #1;
    rx_valid_i = 1'b0;
    pop_i      = 1'b0;
    clr_i      = 1'b0;
    ovr_clr_i  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_count"},   count_o,   32'd0);
    checkOutput({tag, "_empty"},   empty_o,   32'd1);
    checkOutput({tag, "_full"},    full_o,    32'd0);
    checkOutput({tag, "_overrun"}, overrun_o, 32'd0);
    checkOutput({tag, "_timeout"}, timeout_o, 32'd0);
    checkOutput({tag, "_intr"},    intr_rx_o, 32'd0);
    checkOutput({tag, "_rdata"},   rdata_o,   32'd0);
  endtask

  // Reset lands between clock edges so its asynchronous effect is visible
  task automatic applyReset();
    #2;
    rst_ni = 1'b0;
    modelReset();
    #1;
    checkResetValues("midreset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  always @(negedge clk_i) begin
    if (cmp_en) begin
      checkOutput("cyc_rdata",   rdata_o,   modelHead());
      checkOutput("cyc_count",   count_o,   mq.size());
      checkOutput("cyc_empty",   empty_o,   mq.size() == 0);
      checkOutput("cyc_full",    full_o,    mq.size() == DEPTH);
      checkOutput("cyc_overrun", overrun_o, m_ovr);
      checkOutput("cyc_timeout", timeout_o, m_to);
      checkOutput("cyc_intr",    intr_rx_o, m_intr);
    end
  end

  initial begin
    logic [7:0] last;
    rst_ni     = 1'b0;
    rx_byte_i  = 8'h00;
    rx_valid_i = 1'b0;
    pop_i      = 1'b0;
    clr_i      = 1'b0;
    ovr_clr_i  = 1'b0;
    thresh_i   = '0;
    timeout_i  = '0;
    modelReset();
    repeat (3) @(posedge clk_i);
    #1;
    checkResetValues("reset");
    rst_ni = 1'b1;
    cmp_en = 1'b1;

    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    checkOutput("push_rdata", rdata_o, 32'hA5);
    checkOutput("push_count", count_o, 32'd1);
    checkOutput("push_empty", empty_o, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("pop_count", count_o, 32'd0);
    checkOutput("pop_empty", empty_o, 32'd1);
    checkOutput("pop_rdata", rdata_o, 32'd0);

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("fill_full", full_o, 32'd1);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_flag", overrun_o, 32'd1);
    checkOutput("ovr_count", count_o, 32'd16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_order", rdata_o, i);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("drain_empty", empty_o, 32'd1);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_clear", overrun_o, 32'd0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    checkOutput("fullpp_ovr", overrun_o, 32'd0);
    checkOutput("fullpp_count", count_o, 32'd16);
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last = rdata_o;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("fullpp_last", last, 32'h77);

    thresh_i = 5'd4;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("thr_below", intr_rx_o, 32'd0);
    applyStimulus(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("thr_hit", intr_rx_o, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idleCycles(1);
    checkOutput("thr_drop", intr_rx_o, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    thresh_i = '0;

    timeout_i = 16'd10;
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    idleCycles(5);
    checkOutput("to_early", timeout_o, 32'd0);
    idleCycles(7);
    checkOutput("to_flag", timeout_o, 32'd1);
    checkOutput("to_intr", intr_rx_o, 32'd1);
    applyStimulus(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
    checkOutput("to_cleared", timeout_o, 32'd0);
    timeout_i = 16'd0;
    idleCycles(40);
    checkOutput("to_disabled", timeout_o, 32'd0);
    checkOutput("to_dis_intr", intr_rx_o, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("clr_pre_count", count_o, 32'd5);
    checkOutput("clr_pre_ovr", overrun_o, 32'd1);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_count", count_o, 32'd0);
    checkOutput("clr_empty", empty_o, 32'd1);
    checkOutput("clr_ovr", overrun_o, 32'd0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int   bias;
      logic v, p, c, oc;
      if (cyc % 500 == 0) begin
        thresh_i  = (AW+1)'($urandom_range(0, 20));
        timeout_i = 16'($urandom_range(0, 12));
      end
      if (cyc == 1500) applyReset();
      bias = (cyc / 250) % 4;
      case (bias)
        0:       begin v = ($urandom_range(0, 3) != 0);  p = ($urandom_range(0, 3) == 0);  end
        1:       begin v = ($urandom_range(0, 3) == 0);  p = ($urandom_range(0, 3) != 0);  end
        2:       begin v = ($urandom_range(0, 1) == 1);  p = ($urandom_range(0, 1) == 1);  end
        default: begin v = ($urandom_range(0, 15) == 0); p = ($urandom_range(0, 31) == 0); end
      endcase
      c  = ($urandom_range(0, 127) == 0);
      oc = ($urandom_range(0, 15) == 0);
      applyStimulus(v, 8'($urandom), p, c, oc);
    end

    @(negedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It captures each received byte on the receiver's single-cycle data-valid pulse and stores it in a show-ahead FIFO. It exposes pop/flush/status signals to the peripheral register interface. It raises a receive interrupt on a fill threshold or on a character-idle timeout, which replaces the single-entry rx_reg/rx_status scheme.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
AW, $clog2(DEPTH), pointer width (derived; not to be overridden)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
rx_byte_i  in  8  received byte from receiver
rx_valid_i  in  1  one-cycle pulse; rx_byte_i valid
pop_i  in  1  bus read of data register; consume head entry
clr_i  in  1  flush FIFO
ovr_clr_i  in  1  clear sticky overrun flag
thresh_i  in  AW+1  interrupt fill threshold; 0 disables threshold interrupt
timeout_i  in  16  idle-cycle timeout; 0 disables timeout
rdata_o  out  8  head entry (show-ahead); 0 when empty
count_o  out  AW+1  number of stored entries, 0..DEPTH
empty_o  out  1  count_o == 0
full_o  out  1  count_o == DEPTH
overrun_o  out  1  sticky; byte dropped because FIFO was full
timeout_o  out  1  sticky idle-timeout flag
intr_rx_o  out  1  receive interrupt

Behaviour:
- Reset (async, rst_ni=0): pointers=0, count_o=0, empty_o=1, full_o=0, overrun_o=0, timeout_o=0, idle counter=0, intr_rx_o=0, rdata_o=0. Storage contents are not reset.
- Push: rx_valid_i=1 and not full. Byte is written at wr_ptr; wr_ptr+1 (wraps modulo DEPTH); count+1. The byte is visible on rdata_o the cycle after the push when the FIFO was empty.
- Pop: pop_i=1 and not empty. rd_ptr+1 (wraps); count-1. rdata_o shows the next entry in the following cycle. Pop on empty is ignored with no state change.
- Push and pop in the same cycle:
  - Non-empty, non-full: both performed; count unchanged.
  - Full: both performed; no overrun.
  - Empty: pop ignored; push performed.
- Push while full (no simultaneous pop): byte is dropped; overrun_o is set the next cycle. Storage and pointers are unchanged.
- Overrun flag: sticky until ovr_clr_i. If ovr_clr_i and a new overrun occur in the same cycle, set wins.
- clr_i: pointers and count go to 0 the next cycle and timeout_o is cleared. clr_i wins over push/pop in the same cycle. It does not clear overrun_o.
- Idle counter (16 bit): reset to 0 on push, pop, clr_i, or count==0. Otherwise it increments and saturates at timeout_i.
- Timeout flag: timeout_o is set when timeout_i!=0, count!=0 and the counter reaches timeout_i. It is cleared by push, pop or clr_i. Set and clear in the same cycle: clear wins.
- Interrupt: intr_rx_o is registered and equals ((thresh_i!=0) && (count >= thresh_i)) || timeout_o, computed from the current-cycle state. It asserts one cycle after the condition becomes true.
- Arithmetic: count is AW+1 bits and never exceeds DEPTH or goes below 0. thresh_i > DEPTH means the threshold interrupt never fires.
- Reset mid-operation: all state is abandoned immediately; there is no partial flush.

Decomposition:
- uart_pkg holds: UART_DATA_W=8, UART_RX_TIMEOUT_W=16, and the register offset constants for the new RX_DATA/RX_COUNT/RX_THRESH/RX_TIMEOUT/RX_FLAGS registers used by the register interface.
- One sub-module: uart_fifo_mem. It is a DEPTH×8 register-array, 1-write/1-read, with asynchronous read. Pointer, count, flag and timeout logic stay in uart_rx_fifo.

Test Plan:
- Reset, then push 0xA5 → next cycle: rdata_o=0xA5, count_o=1, empty_o=0. Pop → count_o=0, empty_o=1, rdata_o=0.
- DEPTH=16: push 0x00..0x0F → full_o=1. Push 0x55 → overrun_o=1 and count stays 16. Pop all 16 → values 0x00..0x0F in order, with pointer wrap verified.
- Full FIFO with push 0x77 and pop in the same cycle → overrun_o=0, count_o=16. After draining, last byte read = 0x77.
- thresh_i=4: push 3 bytes → intr_rx_o=0. Push 4th → intr_rx_o=1 one cycle later. Pop 1 → intr_rx_o=0.
- timeout_i=10, thresh_i=0: push 1 byte, then idle → timeout_o and intr_rx_o=1 at 10 idle cycles. Push again → timeout_o cleared. With timeout_i=0 → no timeout ever.
- With 5 entries, assert clr_i with simultaneous rx_valid_i and ovr_clr_i while overrun_o=1 → count_o=0, empty_o=1, overrun_o=0. Assert rst_ni=0 mid-stream → all outputs at reset values asynchronously.
